// File: rtl/warp_collector_if.sv
// Handshake and plugin bus between the warp collector, the plugin slots and
// the downstream result consumer. The collector takes the slave view.
interface warp_collector_if #(
  parameter int N_PLUGINS   = 5,
  parameter int WARP_WIDTH  = 16,
  parameter int ERROR_WIDTH = 32
);
  logic                             cmd_start;
  logic                             busy;
  logic                             plugin_start;
  logic [N_PLUGINS-1:0]             plugin_valid;
  logic [N_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x;
  logic [N_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y;
  logic [N_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z;
  logic [N_PLUGINS*ERROR_WIDTH-1:0] plugin_error;
  logic                             result_valid;
  logic                             result_ready;
  logic [WARP_WIDTH-1:0]            sum_x;
  logic [WARP_WIDTH-1:0]            sum_y;
  logic [WARP_WIDTH-1:0]            sum_z;
  logic [ERROR_WIDTH-1:0]           error_sum;
  logic                             err_exceed;
  logic                             warp_overflow;
  logic [N_PLUGINS-1:0]             missing_mask;

  modport master (
    output cmd_start, plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z,
           plugin_error, result_ready,
    input  busy, plugin_start, result_valid, sum_x, sum_y, sum_z, error_sum,
           err_exceed, warp_overflow, missing_mask
  );

  modport slave (
    input  cmd_start, plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z,
           plugin_error, result_ready,
    output busy, plugin_start, result_valid, sum_x, sum_y, sum_z, error_sum,
           err_exceed, warp_overflow, missing_mask
  );
endinterface

// File: rtl/warp_collector.sv
// Warp collector: pulses all plugins, gathers their sticky valids over a
// bounded window, then walks the slots one per cycle accumulating warp and
// error, and presents saturated results on a valid/ready handshake.
module warp_collector #(
  parameter int N_PLUGINS      = 5,
  parameter int WARP_WIDTH     = 16,
  parameter int ERROR_WIDTH    = 32,
  parameter int COLLECT_CYCLES = 8,
  parameter int ERR_THRESHOLD  = 10
) (
  input logic             clk,
  input logic             rst,
  warp_collector_if.slave bus
);
  localparam int IDXW = (N_PLUGINS > 1) ? $clog2(N_PLUGINS) : 1;
  localparam int CW   = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
  localparam int AW   = WARP_WIDTH + $clog2(N_PLUGINS) + 1;
  localparam int EW   = ERROR_WIDTH + 1;

  // Clamp bounds of a WARP_WIDTH signed value, expressed at accumulator width.
  localparam logic signed [AW-1:0] SMAX = {{(AW-WARP_WIDTH+1){1'b0}}, {(WARP_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {S_IDLE, S_START, S_COLLECT, S_ACCUM, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [N_PLUGINS-1:0]   mask_q;
  logic [CW-1:0]          cnt_q;
  logic [IDXW-1:0]        idx_q;
  logic signed [AW-1:0]   acc_x_q, acc_y_q, acc_z_q;
  logic [EW-1:0]          acc_e_q;

  logic                   res_vld_q, ovf_q, exceed_q;
  logic [WARP_WIDTH-1:0]  sx_q, sy_q, sz_q;
  logic [ERROR_WIDTH-1:0] esum_q;
  logic [N_PLUGINS-1:0]   miss_q;

  // Per-slot views of the packed plugin buses.
  logic signed [WARP_WIDTH-1:0] wx [N_PLUGINS];
  logic signed [WARP_WIDTH-1:0] wy [N_PLUGINS];
  logic signed [WARP_WIDTH-1:0] wz [N_PLUGINS];
  logic [ERROR_WIDTH-1:0]       we [N_PLUGINS];

  for (genvar g = 0; g < N_PLUGINS; g++) begin : g_slot
    assign wx[g] = bus.plugin_warp_x[g*WARP_WIDTH +: WARP_WIDTH];
    assign wy[g] = bus.plugin_warp_y[g*WARP_WIDTH +: WARP_WIDTH];
    assign wz[g] = bus.plugin_warp_z[g*WARP_WIDTH +: WARP_WIDTH];
    assign we[g] = bus.plugin_error[g*ERROR_WIDTH +: ERROR_WIDTH];
  end

  logic [N_PLUGINS-1:0] mask_nxt;
  logic                 all_in, last_cnt, last_idx, take;

  assign mask_nxt = mask_q | bus.plugin_valid;
  assign all_in   = &mask_nxt;
  assign last_cnt = (cnt_q == CW'(COLLECT_CYCLES - 1));
  assign last_idx = (idx_q == IDXW'(N_PLUGINS - 1));
  assign take     = mask_q[idx_q];

  // Selected slot, sign-extended, gated by the collected mask.
  logic signed [WARP_WIDTH-1:0] sel_x, sel_y, sel_z;
  logic signed [AW-1:0]         add_x, add_y, add_z;
  logic signed [AW-1:0]         acc_x_nxt, acc_y_nxt, acc_z_nxt;
  logic [EW:0]                  e_wide;
  logic [EW-1:0]                acc_e_nxt;

  assign sel_x = wx[idx_q];
  assign sel_y = wy[idx_q];
  assign sel_z = wz[idx_q];
  assign add_x = take ? {{(AW-WARP_WIDTH){sel_x[WARP_WIDTH-1]}}, sel_x} : '0;
  assign add_y = take ? {{(AW-WARP_WIDTH){sel_y[WARP_WIDTH-1]}}, sel_y} : '0;
  assign add_z = take ? {{(AW-WARP_WIDTH){sel_z[WARP_WIDTH-1]}}, sel_z} : '0;
  assign acc_x_nxt = acc_x_q + add_x;
  assign acc_y_nxt = acc_y_q + add_y;
  assign acc_z_nxt = acc_z_q + add_z;
  assign e_wide    = {1'b0, acc_e_q} + (EW+1)'(take ? we[idx_q] : '0);
  assign acc_e_nxt = e_wide[EW] ? '1 : e_wide[EW-1:0];

  // Final clamping, evaluated on the last ACCUM step so DONE sees it at once.
  logic [WARP_WIDTH-1:0]  cx, cy, cz;
  logic                   ox, oy, oz;
  logic [ERROR_WIDTH-1:0] esum_nxt;

  assign ox = (acc_x_nxt > SMAX) || (acc_x_nxt < SMIN);
  assign oy = (acc_y_nxt > SMAX) || (acc_y_nxt < SMIN);
  assign oz = (acc_z_nxt > SMAX) || (acc_z_nxt < SMIN);
  assign cx = (acc_x_nxt > SMAX) ? SMAX[WARP_WIDTH-1:0] :
              (acc_x_nxt < SMIN) ? SMIN[WARP_WIDTH-1:0] : acc_x_nxt[WARP_WIDTH-1:0];
  assign cy = (acc_y_nxt > SMAX) ? SMAX[WARP_WIDTH-1:0] :
              (acc_y_nxt < SMIN) ? SMIN[WARP_WIDTH-1:0] : acc_y_nxt[WARP_WIDTH-1:0];
  assign cz = (acc_z_nxt > SMAX) ? SMAX[WARP_WIDTH-1:0] :
              (acc_z_nxt < SMIN) ? SMIN[WARP_WIDTH-1:0] : acc_z_nxt[WARP_WIDTH-1:0];
  assign esum_nxt = acc_e_nxt[EW-1] ? '1 : acc_e_nxt[ERROR_WIDTH-1:0];

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.cmd_start) state_d = S_START;
      S_START:   state_d = S_COLLECT;
      S_COLLECT: if (all_in || last_cnt) state_d = S_ACCUM;
      S_ACCUM:   if (last_idx) state_d = S_DONE;
      S_DONE:    if (bus.result_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Collection, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      acc_z_q   <= '0;
      acc_e_q   <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      exceed_q  <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
      sz_q      <= '0;
      esum_q    <= '0;
      miss_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mask_q  <= '0;
          cnt_q   <= '0;
          idx_q   <= '0;
          acc_x_q <= '0;
          acc_y_q <= '0;
          acc_z_q <= '0;
          acc_e_q <= '0;
        end
        S_START: cnt_q <= '0;
        S_COLLECT: begin
          mask_q <= mask_nxt;
          if (!(all_in || last_cnt)) cnt_q <= cnt_q + CW'(1);
        end
        S_ACCUM: begin
          acc_x_q <= acc_x_nxt;
          acc_y_q <= acc_y_nxt;
          acc_z_q <= acc_z_nxt;
          acc_e_q <= acc_e_nxt;
          idx_q   <= idx_q + IDXW'(1);
          if (last_idx) begin
            sx_q      <= cx;
            sy_q      <= cy;
            sz_q      <= cz;
            ovf_q     <= ox | oy | oz;
            esum_q    <= esum_nxt;
            exceed_q  <= (esum_nxt > ERROR_WIDTH'(ERR_THRESHOLD));
            miss_q    <= ~mask_q;
            res_vld_q <= 1'b1;
          end
        end
        S_DONE: if (bus.result_ready) res_vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.plugin_start  = (state_q == S_START);
  assign bus.result_valid  = res_vld_q;
  assign bus.sum_x         = sx_q;
  assign bus.sum_y         = sy_q;
  assign bus.sum_z         = sz_q;
  assign bus.error_sum     = esum_q;
  assign bus.err_exceed    = exceed_q;
  assign bus.warp_overflow = ovf_q;
  assign bus.missing_mask  = miss_q;
endmodule

// File: doc/warp_collector.md
Name: warp_collector

Overview:
- Downstream consumer of the ISO‑16 plugin family (ALPHA…EPSILON).
- Issues a single start pulse to all plugins, then collects their latched outputs over a bounded COLLECT window.
- Produces saturated per‑axis warp sums, a saturated error sum, a threshold flag, and a missing‑plugin mask.
- Results go to the next stage through a valid/ready handshake.

Parameters:
N_PLUGINS, 5, number of plugin slots (index 0 = ALPHA … 4 = EPSILON)
WARP_WIDTH, 16, signed warp component width
ERROR_WIDTH, 32, unsigned plugin error width
COLLECT_CYCLES, 8, max cycles spent in COLLECT (≥1)
ERR_THRESHOLD, 10, error_sum strictly above this sets err_exceed

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_start  in  1  request a collection run; honoured only in IDLE
busy  out  1  high in every state except IDLE
plugin_start  out  1  one-cycle start pulse broadcast to all plugins
plugin_valid  in  N_PLUGINS  per-plugin valid, sticky high
plugin_warp_x  in  N_PLUGINS*WARP_WIDTH  packed, slot i at [i*WARP_WIDTH +: WARP_WIDTH]
plugin_warp_y  in  N_PLUGINS*WARP_WIDTH  packed as above
plugin_warp_z  in  N_PLUGINS*WARP_WIDTH  packed as above
plugin_error  in  N_PLUGINS*ERROR_WIDTH  packed, unsigned
result_valid  out  1  result outputs valid
result_ready  in  1  downstream accepts result
sum_x / sum_y / sum_z  out  WARP_WIDTH each  saturated signed sums
error_sum  out  ERROR_WIDTH  saturated unsigned error sum
err_exceed  out  1  error_sum > ERR_THRESHOLD
warp_overflow  out  1  any axis saturated
missing_mask  out  N_PLUGINS  bit i set if slot i never asserted valid in COLLECT

Behaviour:
Clock and reset:
- One clock, clk.
- rst is asynchronous and active-high. Asserting it forces state IDLE and zeroes every output, mask, counter and accumulator immediately. This includes reset mid-run; plugin_start drops without waiting for a clock edge.

FSM states: IDLE, START, COLLECT, ACCUM, DONE.
- IDLE: if cmd_start=1, go to START. Clear the valid mask, accumulators and counters.
- START: plugin_start=1 for exactly this one cycle; go to COLLECT with cnt=0.
- COLLECT: each cycle, mask <= mask | plugin_valid. Go to ACCUM when (mask | plugin_valid) is all ones, or when cnt == COLLECT_CYCLES-1. Otherwise cnt++.
- ACCUM: one slot per cycle, idx = 0 … N_PLUGINS-1.
  - If mask[idx] is set, add that slot's sign-extended warp x/y/z and its error into internal accumulators.
  - Warp accumulators are WARP_WIDTH+clog2(N_PLUGINS)+1 bits, signed.
  - The error accumulator is ERROR_WIDTH+1 bits and saturates each step at all ones.
  - After idx = N_PLUGINS-1, go to DONE.
- DONE entry:
  - Register each axis sum, clamped to [-2^(WARP_WIDTH-1), 2^(WARP_WIDTH-1)-1].
  - Set warp_overflow if any axis was clamped.
  - Set error_sum, err_exceed, missing_mask = ~mask.
  - Raise result_valid.
- DONE: hold all result outputs stable while result_valid=1 and result_ready=0. On result_valid & result_ready, go to IDLE; result_valid falls next cycle.
- After the handshake, result outputs keep their last values until the next START.

Plugin inputs:
- Plugins must hold their data stable from valid until result_valid. The collector reads data live during ACCUM.
- A valid that was already high before START (stale from a prior run) is accepted. Plugins re-latch on plugin_start.

Other rules:
- cmd_start outside IDLE is ignored.
- Latency with all plugins valid on the first COLLECT cycle: cmd_start at cycle T gives plugin_start at T+1, COLLECT at T+2, ACCUM at T+3 … T+2+N_PLUGINS, result_valid at T+3+N_PLUGINS (T+8 with defaults).
- Timeout latency is COLLECT_CYCLES-1 cycles longer.
- Slots excluded by the mask contribute zero.
- An all-missing run yields all sums 0, err_exceed=0, missing_mask all ones.

Test Plan:
- Reset mid-COLLECT: assert rst for 1 cycle -> busy=0, plugin_start=0, result_valid=0, all outputs 0 asynchronously; next cmd_start runs normally.
- All five plugins valid one cycle after plugin_start, with errors 1,2,3,4,5 and x = 10,20,30,40,50 -> result_valid at T+8, sum_x=150, error_sum=15, err_exceed=1, missing_mask=0, warp_overflow=0.
- Slots 3 and 4 both EPSILON-like (x=0x7FFF, y=0x8000, z=0x2000, error 5), others zero -> sum_x=0x7FFF, sum_y=0x8000, sum_z=0x4000, warp_overflow=1, error_sum=10, err_exceed=0.
- Slot 2 never valid, others valid -> exits COLLECT after exactly COLLECT_CYCLES=8 cycles; missing_mask=5'b00100; slot 2 data of 0x1234 excluded from sums.
- result_ready held 0 for 5 cycles in DONE, and a cmd_start pulse during DONE -> outputs stable, cmd_start ignored; ready=1 -> IDLE next cycle, result_valid=0.
- Errors 0xFFFFFFFF on two slots -> error_sum=0xFFFFFFFF, err_exceed=1.
